circle_trace_ctrl: RTL and testbench



---
 rtl/circle_trace_ctrl_if.sv | 12 +
 rtl/circle_trace_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_circle_trace_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_trace_ctrl_if.sv
// rtl/circle_trace_ctrl_if.sv - point stream interface between circle_trace_ctrl and the voxel writer
interface circle_trace_ctrl_if #(
   parameter int W = 16
);
   logic signed [W-1:0] out_x;
   logic signed [W-1:0] out_y;
   logic                out_valid;
   logic                out_ready;

   modport master (output out_x, output out_y, output out_valid, input out_ready);
   modport slave  (input out_x, input out_y, input out_valid, output out_ready);
endinterface

// File: rtl/circle_trace_ctrl.sv
// rtl/circle_trace_ctrl.sv - counter-clockwise lattice circle tracer streaming points over valid/ready
// Optional step watchdog is built when CIRCLE_CTRL_WATCHDOG_EN is defined; otherwise err is tied low.
module circle_trace_ctrl #(
   parameter int W     = 16,
   parameter int MAX_R = 127
) (
   input  logic                gclock,
   input  logic                reset,
   input  logic                start,
   input  logic [W-1:0]        r,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                err,
   circle_trace_ctrl_if.master pts
);
   localparam int           AW     = 2*W + 2;
   localparam logic [W-1:0] MAX_RW = W'(MAX_R);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_CALC, S_DONE} state_t;

   state_t               r_state;
   logic signed [W-1:0]  r_x;
   logic signed [W-1:0]  r_y;
   logic [W-1:0]         r_rr;
   logic signed [AW-1:0] r_r2;
   logic                 r_valid;
   logic                 r_busy;
   logic                 r_done;

   logic [W-1:0]         w_rr_in;
   logic signed [AW-1:0] w_rr_e;
   logic                 w_x_pos, w_x_zero, w_y_pos, w_y_neg, w_y_zero;
   logic signed [W-1:0]  w_sx, w_sy, w_xs, w_ys, w_nx, w_ny;
   logic signed [AW-1:0] w_x_e, w_y_e, w_xs_e, w_ys_e;
   logic signed [AW-1:0] w_xx, w_yy, w_xsxs, w_ysys;
   logic signed [AW-1:0] w_d1, w_d2, w_d3;
   logic [AW-1:0]        w_a1, w_a2, w_a3;
   logic                 w_pick3, w_pick1, w_close, w_wd_trip;

   // Radius saturation and its square, widened so nothing truncates
   assign w_rr_in = (r > MAX_RW) ? MAX_RW : r;
   assign w_rr_e  = $signed({{(AW-W){1'b0}}, w_rr_in});

   // Quadrant of the current point decides the step directions
   assign w_x_pos  = !r_x[W-1] && (|r_x);
   assign w_x_zero = ~|r_x;
   assign w_y_pos  = !r_y[W-1] && (|r_y);
   assign w_y_neg  = r_y[W-1];
   assign w_y_zero = ~|r_y;
   assign w_sx = (w_y_pos || (w_y_zero && w_x_pos)) ? '1 : W'(1);
   assign w_sy = (w_x_pos || (w_x_zero && w_y_neg)) ? W'(1) : '1;
   assign w_xs = r_x + w_sx;
   assign w_ys = r_y + w_sy;

   // Sign-extend to the wide arithmetic width before squaring
   assign w_x_e  = $signed({{(AW-W){r_x[W-1]}},  r_x});
   assign w_y_e  = $signed({{(AW-W){r_y[W-1]}},  r_y});
   assign w_xs_e = $signed({{(AW-W){w_xs[W-1]}}, w_xs});
   assign w_ys_e = $signed({{(AW-W){w_ys[W-1]}}, w_ys});
   assign w_xx   = w_x_e  * w_x_e;
   assign w_yy   = w_y_e  * w_y_e;
   assign w_xsxs = w_xs_e * w_xs_e;
   assign w_ysys = w_ys_e * w_ys_e;

   // Candidate radial errors: d1 vertical, d2 horizontal, d3 diagonal
   assign w_d1 = w_xx   + w_ysys - r_r2;
   assign w_d2 = w_xsxs + w_yy   - r_r2;
   assign w_d3 = w_xsxs + w_ysys - r_r2;
   assign w_a1 = w_d1[AW-1] ? $unsigned(-w_d1) : $unsigned(w_d1);
   assign w_a2 = w_d2[AW-1] ? $unsigned(-w_d2) : $unsigned(w_d2);
   assign w_a3 = w_d3[AW-1] ? $unsigned(-w_d3) : $unsigned(w_d3);

   // Minimum |d| wins; ties resolve diagonal first, then vertical, then horizontal
   assign w_pick3 = (w_a3 <= w_a1) && (w_a3 <= w_a2);
   assign w_pick1 = !w_pick3 && (w_a1 <= w_a2);
   assign w_nx    = w_pick1 ? r_x : w_xs;
   assign w_ny    = (w_pick3 || w_pick1) ? w_ys : r_y;
   assign w_close = (w_nx == $signed(r_rr)) && (w_ny == '0);

`ifdef CIRCLE_CTRL_WATCHDOG_EN
   logic [W+3:0] r_wd_cnt;
   logic [W+3:0] w_wd_limit;
   logic         r_err;

   assign w_wd_limit = {1'b0, r_rr, 3'b000} + (W+4)'(8);
   assign w_wd_trip  = (r_state == S_CALC) && !w_close && ((r_wd_cnt + (W+4)'(1)) >= w_wd_limit);
   assign err        = r_err;

   // Step watchdog: counts CALC cycles per trace and pulses err when closure never comes
   always_ff @(posedge gclock) begin
      if (reset) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (!abort && (r_state == S_IDLE) && start) begin
            r_wd_cnt <= '0;
         end else if (!abort && (r_state == S_CALC)) begin
            r_wd_cnt <= r_wd_cnt + (W+4)'(1);
            r_err    <= w_wd_trip;
         end
      end
   end
`else
   assign w_wd_trip = 1'b0;
   assign err       = 1'b0;
`endif

   // Sequencer: state, current point and registered stream/status outputs
   always_ff @(posedge gclock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_rr    <= '0;
         r_r2    <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rr    <= w_rr_in;
                  r_r2    <= w_rr_e * w_rr_e;
                  r_x     <= $signed(w_rr_in);
                  r_y     <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (pts.out_ready) begin
                  r_valid <= 1'b0;
                  if (r_rr == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (w_close) begin
                  r_x     <= w_nx;
                  r_y     <= w_ny;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_wd_trip) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_x     <= w_nx;
                  r_y     <= w_ny;
                  r_valid <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pts.out_x     = r_x;
   assign pts.out_y     = r_y;
   assign pts.out_valid = r_valid;
   assign busy          = r_busy;
   assign done          = r_done;
endmodule

// File: tb/tb_circle_trace_ctrl.sv
// tb/tb_circle_trace_ctrl.sv - randomized model-checked bench for circle_trace_ctrl
module tb_circle_trace_ctrl;
   localparam int W = 16;

   logic         gclock = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         err;

   circle_trace_ctrl_if #(.W(W)) pts ();

   circle_trace_ctrl #(.W(W), .MAX_R(127)) dut (
      .gclock (gclock),
      .reset  (reset),
      .start  (start),
      .r      (r),
      .abort  (abort),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .pts    (pts)
   );

   always #5 gclock = ~gclock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_done_cyc = -1;
   int cur_rr = 0;
   int ready_mode = 0;
   bit mon_en = 1'b0;
   int mdl_x[$], mdl_y[$];
   int exp_x[$], exp_y[$];
   int got_x[$], got_y[$];
   int ref_x[$], ref_y[$];

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int absi(int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference path: from (rr,0) walk to the neighbour nearest the circle until back at the start
   function automatic void model_path(int rr);
      int x, y, sx, sy, best, be, e;
      int cx[3];
      int cy[3];
      mdl_x.delete();
      mdl_y.delete();
      x = rr;
      y = 0;
      mdl_x.push_back(x);
      mdl_y.push_back(y);
      if (rr == 0) return;
      for (int n = 0; n < 8192; n++) begin
         sx = (y > 0 || (y == 0 && x > 0)) ? -1 : 1;
         sy = (x > 0 || (x == 0 && y < 0)) ? 1 : -1;
         cx[0] = x + sx; cy[0] = y + sy;
         cx[1] = x;      cy[1] = y + sy;
         cx[2] = x + sx; cy[2] = y;
         best = 0;
         be = absi(cx[0]*cx[0] + cy[0]*cy[0] - rr*rr);
         for (int k = 1; k < 3; k++) begin
            e = absi(cx[k]*cx[k] + cy[k]*cy[k] - rr*rr);
            if (e < be) begin
               be = e;
               best = k;
            end
         end
         x = cx[best];
         y = cy[best];
         if (x == rr && y == 0) break;
         mdl_x.push_back(x);
         mdl_y.push_back(y);
      end
   endfunction

   // Consumer ready pattern: always, one cycle in three, or random
   initial begin
      int k;
      k = 0;
      pts.out_ready = 1'b1;
      forever begin
         @(posedge gclock);
         #1;
         k++;
         case (ready_mode)
            0:       pts.out_ready = 1'b1;
            1:       pts.out_ready = ((k % 3) == 0);
            default: pts.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Per-cycle compare against the model queue, done timing, stall stability and err
   initial begin
      bit prev_stall, prev_guard;
      int px, py;
      prev_stall = 1'b0;
      prev_guard = 1'b0;
      px = 0;
      py = 0;
      forever begin
         @(negedge gclock);
         cyc++;
         if (mon_en) begin
            chk("err_low", int'(err), 0);
            chk("done_timing", int'(done), int'(cyc == exp_done_cyc));
            if (prev_stall && !prev_guard) begin
               chk("stall_valid", int'(pts.out_valid), 1);
               chk("stall_x", int'(pts.out_x), px);
               chk("stall_y", int'(pts.out_y), py);
            end
            if (pts.out_valid) chk("busy_with_valid", int'(busy), 1);
            if (pts.out_valid && pts.out_ready) begin
               if (exp_x.size() == 0) begin
                  chk("extra_point", 1, 0);
               end else begin
                  chk("point_x", int'(pts.out_x), exp_x[0]);
                  chk("point_y", int'(pts.out_y), exp_y[0]);
                  void'(exp_x.pop_front());
                  void'(exp_y.pop_front());
                  if (exp_x.size() == 0) exp_done_cyc = cyc + ((cur_rr == 0) ? 1 : 2);
               end
               got_x.push_back(int'(pts.out_x));
               got_y.push_back(int'(pts.out_y));
            end
         end
         prev_stall = pts.out_valid && !pts.out_ready;
         prev_guard = abort || reset;
         px = int'(pts.out_x);
         py = int'(pts.out_y);
      end
   end

   task automatic begin_trace(input int rin);
      int rr;
      rr = (rin > 127) ? 127 : rin;
      model_path(rr);
      exp_x = mdl_x;
      exp_y = mdl_y;
      got_x.delete();
      got_y.delete();
      cur_rr = rr;
      exp_done_cyc = -1;
      @(posedge gclock);
      #1;
      r = W'(rin);
      start = 1'b1;
      @(posedge gclock);
      #1;
      start = 1'b0;
      @(negedge gclock);
      chk("first_valid", int'(pts.out_valid), 1);
      chk("first_x", int'(pts.out_x), rr);
      chk("first_y", int'(pts.out_y), 0);
   endtask

   task automatic run_trace(input int rin, input int mode);
      bit seen;
      ready_mode = mode;
      begin_trace(rin);
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge gclock);
         if (done) seen = 1'b1;
      end
      chk("done_seen", int'(seen), 1);
      @(negedge gclock);
      chk("busy_after_done", int'(busy), 0);
      chk("valid_after_done", int'(pts.out_valid), 0);
      chk("points_remaining", exp_x.size(), 0);
   endtask

   initial begin
      int e1x[4];
      int e1y[4];
      int bad, dup;
      e1x = '{1, 0, -1, 0};
      e1y = '{0, 1, 0, -1};
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      r = '0;

      // Literal pins on the reference model itself
      model_path(1);
      chk("model_r1_len", mdl_x.size(), 4);
      for (int i = 0; i < 4 && i < mdl_x.size(); i++) begin
         chk("model_r1_x", mdl_x[i], e1x[i]);
         chk("model_r1_y", mdl_y[i], e1y[i]);
      end
      model_path(0);
      chk("model_r0_len", mdl_x.size(), 1);
      model_path(2);
      chk("model_r2_p1x", mdl_x[1], 2);
      chk("model_r2_p1y", mdl_y[1], 1);
      chk("model_r2_mult4", mdl_x.size() % 4, 0);
      bad = 0;
      dup = 0;
      for (int i = 0; i < mdl_x.size(); i++) begin
         if (absi(mdl_x[i]*mdl_x[i] + mdl_y[i]*mdl_y[i] - 4) > 2) bad++;
         for (int j = i + 1; j < mdl_x.size(); j++)
            if (mdl_x[i] == mdl_x[j] && mdl_y[i] == mdl_y[j]) dup++;
      end
      chk("model_r2_err_bound", bad, 0);
      chk("model_r2_no_dup", dup, 0);

      // Reset state
      repeat (3) @(posedge gclock);
      #1;
      reset = 1'b0;
      @(negedge gclock);
      chk("rst_valid", int'(pts.out_valid), 0);
      chk("rst_x", int'(pts.out_x), 0);
      chk("rst_y", int'(pts.out_y), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      mon_en = 1'b1;

      run_trace(1, 0);
      chk("r1_count", got_x.size(), 4);
      run_trace(0, 0);
      chk("r0_count", got_x.size(), 1);
      run_trace(2, 0);
      chk("r2_count_mult4", got_x.size() % 4, 0);

      // Stalled consumer must see the same sequence
      run_trace(5, 0);
      ref_x = got_x;
      ref_y = got_y;
      run_trace(5, 1);
      chk("r5_stall_len", got_x.size(), ref_x.size());
      bad = 0;
      for (int i = 0; i < got_x.size() && i < ref_x.size(); i++)
         if (got_x[i] != ref_x[i] || got_y[i] != ref_y[i]) bad++;
      chk("r5_stall_seq", bad, 0);

      // Saturated radius
      run_trace(300, 0);

      // Watchdog must stay quiet on a normal trace
      run_trace(3, 0);

      // Abort mid-trace together with start
      ready_mode = 0;
      begin_trace(5);
      repeat (6) @(negedge gclock);
      @(posedge gclock);
      #1;
      abort = 1'b1;
      start = 1'b1;
      r = W'(5);
      @(posedge gclock);
      #1;
      abort = 1'b0;
      start = 1'b0;
      exp_x.delete();
      exp_y.delete();
      exp_done_cyc = -1;
      @(negedge gclock);
      chk("abort_valid", int'(pts.out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      run_trace(1, 0);
      chk("post_abort_count", got_x.size(), 4);

      // Reset mid-trace
      begin_trace(6);
      repeat (5) @(negedge gclock);
      mon_en = 1'b0;
      @(posedge gclock);
      #1;
      reset = 1'b1;
      @(posedge gclock);
      #1;
      reset = 1'b0;
      exp_x.delete();
      exp_y.delete();
      exp_done_cyc = -1;
      @(negedge gclock);
      chk("midrst_valid", int'(pts.out_valid), 0);
      chk("midrst_x", int'(pts.out_x), 0);
      chk("midrst_y", int'(pts.out_y), 0);
      chk("midrst_busy", int'(busy), 0);
      mon_en = 1'b1;

      // Randomized radii under a random consumer
      for (int t = 0; t < 10; t++)
         run_trace(int'($urandom_range(0, 24)), 2);
      run_trace(int'($urandom_range(128, 2000)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
